// File: rtl/ripple_cnt_sampler_if.sv
// ----------------------------------------------------------------------------
// ripple_cnt_sampler_if
//
// Purpose:
//    Valid/ready output channel that carries each new running total from
//    the ripple counter sampler to the next stage.
//
// Signals:
//    out_valid  producer -> consumer  out_data holds an unconsumed total
//    out_ready  consumer -> producer  consumer takes out_data at this edge
//    out_data   producer -> consumer  total snapshot at the last acceptance
//
// Modports:
//    master  the sampler (drives valid/data, observes ready)
//    slave   the downstream consumer
// ----------------------------------------------------------------------------
interface ripple_cnt_sampler_if #(
    parameter int EXT_W = 16
);

    logic             out_valid;
    logic             out_ready;
    logic [EXT_W-1:0] out_data;

    modport master (
        output out_valid,
        output out_data,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        output out_ready
    );

endinterface

// File: rtl/ripple_cnt_sampler.sv
// ----------------------------------------------------------------------------
// ripple_cnt_sampler
//
// Purpose:
//    Consumer of a free-running CNT_W-bit ripple counter. The counter bits
//    change asynchronously to clk and glitch while the carry ripples, so
//    they are first passed through a two-flop synchronizer and then only
//    accepted once STABLE consecutive synchronized samples agree. Every
//    accepted value contributes its modulo-2^CNT_W distance from the
//    previously accepted value to a wide running total, and every new total
//    is offered downstream over a valid/ready channel.
//
// Ports:
//    clk       in   system clock, rising edge
//    rst       in   synchronous reset, active-high (beats clr and updates)
//    cnt_in    in   raw ripple counter outputs, asynchronous to clk
//    clr       in   synchronous clear of total, overflow, lost, out_valid
//    cnt_q     out  last accepted counter value
//    total     out  running accumulated count, modulo 2^EXT_W
//    wrap      out  one-cycle pulse when an accepted value wrapped past
//                   2^CNT_W-1
//    overflow  out  sticky: total wrapped past 2^EXT_W-1
//    lost      out  sticky: an unconsumed out_data was overwritten
//    outBus    master side of the valid/ready output channel
// ----------------------------------------------------------------------------
module ripple_cnt_sampler #(
    parameter int CNT_W  = 3,
    parameter int EXT_W  = 16,
    parameter int STABLE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CNT_W-1:0]      cnt_in,
    input  logic                  clr,
    output logic [CNT_W-1:0]      cnt_q,
    output logic [EXT_W-1:0]      total,
    output logic                  wrap,
    output logic                  overflow,
    output logic                  lost,
    ripple_cnt_sampler_if.master  outBus
);

    // ------------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------------
    logic [CNT_W-1:0] sync1_q, sync1_d;
    logic [CNT_W-1:0] sync2_q, sync2_d;
    // Older samples of the synchronized value; entry 0 of the history is
    // sync2_q itself, so only entries 1..STABLE-1 need their own flops.
    logic [CNT_W-1:0] hist_q [1:STABLE-1];
    logic [CNT_W-1:0] hist_d [1:STABLE-1];
    logic [CNT_W-1:0] acceptedCnt_q, acceptedCnt_d;
    logic [EXT_W-1:0] total_q, total_d;
    logic             wrap_q, wrap_d;
    logic             outValid_q, outValid_d;
    logic [EXT_W-1:0] outData_q, outData_d;
    logic             overflow_q, overflow_d;
    logic             lost_q, lost_d;

    // ------------------------------------------------------------------------
    // Datapath helpers
    // ------------------------------------------------------------------------
    logic             historyStable;
    logic             accept;
    logic             wrapNow;
    logic [CNT_W-1:0] delta;
    logic [EXT_W:0]   sum;

    // The settled-value detector: the newest synchronized sample must agree
    // with every older sample in the window before it is trusted. A ripple
    // transient can only survive this if it lasts STABLE whole clock
    // periods, which the counter's ripple never does.
    always_comb begin
        historyStable = 1'b1;
        for (int i = 1; i < STABLE; i++) begin
            if (hist_q[i] != sync2_q) begin
                historyStable = 1'b0;
            end
        end
    end

    // A settled value is only worth accepting when it differs from the one
    // already held; otherwise the counter simply has not moved. The delta is
    // computed in CNT_W bits so the modulo-2^CNT_W wrap falls out of the
    // subtraction naturally, and the extra top bit of the sum is the carry
    // that feeds the sticky overflow flag.
    always_comb begin
        accept  = historyStable && (sync2_q != acceptedCnt_q);
        wrapNow = (sync2_q < acceptedCnt_q);
        delta   = sync2_q - acceptedCnt_q;
        sum     = {1'b0, total_q} + {{(EXT_W + 1 - CNT_W){1'b0}}, delta};
    end

    // ------------------------------------------------------------------------
    // Synchronizer and sample history next state
    // ------------------------------------------------------------------------
    // Two plain flops take the asynchronous counter bits into the clk
    // domain, then the history shifts one place per cycle with the newest
    // synchronized sample entering at entry 1.
    always_comb begin
        sync1_d = cnt_in;
        sync2_d = sync1_q;
        hist_d[1] = sync2_q;
        for (int i = 2; i < STABLE; i++) begin
            hist_d[i] = hist_q[i-1];
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator, flags and output channel next state
    // ------------------------------------------------------------------------
    // cnt_q and wrap follow acceptance regardless of clr, so clearing the
    // total never makes the next acceptance look like a large jump from an
    // old value. clr wins over accumulation and discards that cycle's delta.
    // Without clr, an acceptance always (re)loads the output register; if
    // the previous total was still waiting and not being taken this cycle
    // it is gone, which is what lost records. A completed transfer with no
    // new acceptance simply empties the channel.
    always_comb begin
        acceptedCnt_d = acceptedCnt_q;
        wrap_d        = 1'b0;
        total_d       = total_q;
        overflow_d    = overflow_q;
        lost_d        = lost_q;
        outValid_d    = outValid_q;
        outData_d     = outData_q;

        if (accept) begin
            acceptedCnt_d = sync2_q;
            wrap_d        = wrapNow;
        end

        if (clr) begin
            total_d    = '0;
            overflow_d = 1'b0;
            lost_d     = 1'b0;
            outValid_d = 1'b0;
        end else if (accept) begin
            total_d    = sum[EXT_W-1:0];
            overflow_d = overflow_q | sum[EXT_W];
            outData_d  = sum[EXT_W-1:0];
            outValid_d = 1'b1;
            if (outValid_q && !outBus.out_ready) begin
                lost_d = 1'b1;
            end
        end else if (outValid_q && outBus.out_ready) begin
            outValid_d = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Register update
    // ------------------------------------------------------------------------
    // Reset clears everything, including the synchronizer and history, so
    // that stale pre-reset samples can never be accepted afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            for (int i = 1; i < STABLE; i++) begin
                hist_q[i] <= '0;
            end
            acceptedCnt_q <= '0;
            total_q       <= '0;
            wrap_q        <= 1'b0;
            outValid_q    <= 1'b0;
            outData_q     <= '0;
            overflow_q    <= 1'b0;
            lost_q        <= 1'b0;
        end else begin
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            for (int i = 1; i < STABLE; i++) begin
                hist_q[i] <= hist_d[i];
            end
            acceptedCnt_q <= acceptedCnt_d;
            total_q       <= total_d;
            wrap_q        <= wrap_d;
            outValid_q    <= outValid_d;
            outData_q     <= outData_d;
            overflow_q    <= overflow_d;
            lost_q        <= lost_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs are driven straight from registers
    // ------------------------------------------------------------------------
    assign cnt_q            = acceptedCnt_q;
    assign total            = total_q;
    assign wrap             = wrap_q;
    assign overflow         = overflow_q;
    assign lost             = lost_q;
    assign outBus.out_valid = outValid_q;
    assign outBus.out_data  = outData_q;

endmodule

// File: tb/tb_ripple_cnt_sampler.sv
// ----------------------------------------------------------------------------
// tb_ripple_cnt_sampler
//
// Purpose:
//    Self-checking bench for ripple_cnt_sampler. A narrow total (EXT_W=6)
//    is used so overflow is reached quickly. Directed scenarios are followed
//    by a long randomized run; every cycle all outputs are compared against
//    a behavioural model that works from the list of recently sampled input
//    values and the acceptance/accumulation rules in plain integer math.
// ----------------------------------------------------------------------------
module tb_ripple_cnt_sampler;

    localparam int CNT_W  = 3;
    localparam int EXT_W  = 6;
    localparam int STABLE = 2;
    localparam int CMOD   = 1 << CNT_W;
    localparam int TMOD   = 1 << EXT_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic [CNT_W-1:0] cntIn;
    logic [CNT_W-1:0] cntQ;
    logic [EXT_W-1:0] total;
    logic             wrap;
    logic             overflow;
    logic             lost;

    int checks   = 0;
    int failures = 0;
    int wrapSeen = 0;

    // Behavioural model state
    int mCnt, mTotal, mWrap, mValid, mData, mOverflow, mLost;
    // Input values sampled at the most recent edges, newest first
    int smp [0:STABLE];

    ripple_cnt_sampler_if #(.EXT_W(EXT_W)) bus ();

    ripple_cnt_sampler #(
        .CNT_W  (CNT_W),
        .EXT_W  (EXT_W),
        .STABLE (STABLE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cnt_in   (cntIn),
        .clr      (clr),
        .cnt_q    (cntQ),
        .total    (total),
        .wrap     (wrap),
        .overflow (overflow),
        .lost     (lost),
        .outBus   (bus)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    // Reference behaviour for one rising edge with the inputs currently applied
    task automatic modelEdge();
        bit stable;
        bit acc;
        int cand;
        int newSum;
        if (rst) begin
            mCnt = 0; mTotal = 0; mWrap = 0; mValid = 0;
            mData = 0; mOverflow = 0; mLost = 0;
            for (int i = 0; i <= STABLE; i++) smp[i] = 0;
        end else begin
            // A value counts as settled once the STABLE samples that have
            // made it through the two-flop synchronizer all agree
            cand   = smp[1];
            stable = 1'b1;
            for (int i = 2; i <= STABLE; i++) begin
                if (smp[i] != cand) stable = 1'b0;
            end
            acc    = stable && (cand != mCnt);
            mWrap  = (acc && (cand < mCnt)) ? 1 : 0;
            newSum = mTotal + ((cand - mCnt + CMOD) % CMOD);
            if (clr) begin
                mTotal = 0; mOverflow = 0; mLost = 0; mValid = 0;
            end else if (acc) begin
                if (newSum >= TMOD) mOverflow = 1;
                mTotal = newSum % TMOD;
                if (mValid != 0 && !bus.out_ready) mLost = 1;
                mData  = mTotal;
                mValid = 1;
            end else if (mValid != 0 && bus.out_ready) begin
                mValid = 0;
            end
            if (acc) mCnt = cand;
            for (int i = STABLE; i > 0; i--) smp[i] = smp[i-1];
            smp[0] = int'(cntIn);
        end
    endtask

    // Drive one cycle of inputs, advance the clock, update model, compare
    task automatic applyStimulus(input int cnt, input bit clrV, input bit readyV, input bit rstV);
        cntIn         = CNT_W'(cnt);
        clr           = clrV;
        bus.out_ready = readyV;
        rst           = rstV;
        @(posedge clk);
        modelEdge();
        #1;
        if (wrap) wrapSeen++;
        checkOutput("cnt_q",     int'(cntQ),         mCnt);
        checkOutput("total",     int'(total),        mTotal);
        checkOutput("wrap",      int'(wrap),         mWrap);
        checkOutput("out_valid", int'(bus.out_valid), mValid);
        checkOutput("out_data",  int'(bus.out_data),  mData);
        checkOutput("overflow",  int'(overflow),     mOverflow);
        checkOutput("lost",      int'(lost),         mLost);
    endtask

    // Hold one input value for several cycles
    task automatic holdValue(input int cnt, input int cycles, input bit readyV);
        for (int i = 0; i < cycles; i++) applyStimulus(cnt, 1'b0, readyV, 1'b0);
    endtask

    initial begin
        int val;
        int hold;
        cntIn = '0; clr = 1'b0; rst = 1'b1; bus.out_ready = 1'b0;
        for (int i = 0; i <= STABLE; i++) smp[i] = 0;
        mCnt = 0; mTotal = 0; mWrap = 0; mValid = 0;
        mData = 0; mOverflow = 0; mLost = 0;

        // Reset, then a quiet zero input
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        applyStimulus(0, 1'b0, 1'b0, 1'b1);
        wrapSeen = 0;
        holdValue(0, 10, 1'b0);
        checkOutput("idle_total", int'(total), 0);
        checkOutput("idle_wrap_count", wrapSeen, 0);

        // Full lap of the counter: eight unit steps, one wrap
        wrapSeen = 0;
        for (int v = 1; v <= CMOD; v++) holdValue(v % CMOD, 8, 1'b1);
        checkOutput("lap_total", int'(total), 8);
        checkOutput("lap_wrap_count", wrapSeen, 1);
        checkOutput("lap_cnt_q", int'(cntQ), 0);

        // Single-cycle glitch to 3 is ignored, settled 5 is accepted once
        applyStimulus(3, 1'b0, 1'b1, 1'b0);
        holdValue(5, 8, 1'b1);
        checkOutput("glitch_total", int'(total), 13);
        checkOutput("glitch_cnt_q", int'(cntQ), 5);

        // Two acceptances while the consumer stalls: second overwrites
        holdValue(2, 8, 1'b0);
        holdValue(6, 8, 1'b0);
        checkOutput("stall_out_data", int'(bus.out_data), 22);
        checkOutput("stall_out_valid", int'(bus.out_valid), 1);
        checkOutput("stall_lost", int'(lost), 1);
        applyStimulus(6, 1'b0, 1'b1, 1'b0);
        checkOutput("drain_out_valid", int'(bus.out_valid), 0);

        // clr landing exactly on the 3->4 acceptance edge
        holdValue(3, 8, 1'b1);
        holdValue(4, STABLE + 1, 1'b1);
        applyStimulus(4, 1'b1, 1'b1, 1'b0);
        checkOutput("clracc_cnt_q", int'(cntQ), 4);
        checkOutput("clracc_total", int'(total), 0);
        checkOutput("clracc_out_valid", int'(bus.out_valid), 0);
        holdValue(4, 5, 1'b1);
        checkOutput("clracc_no_reaccept", int'(total), 0);

        // Ten steps of 7 (counting down by one) push the total past 2^6
        val = 4;
        for (int s = 0; s < 10; s++) begin
            val = (val + 7) % CMOD;
            holdValue(val, 5, 1'b1);
        end
        checkOutput("ovf_total", int'(total), 70 % TMOD);
        checkOutput("ovf_flag", int'(overflow), 1);
        applyStimulus(val, 1'b1, 1'b1, 1'b0);
        checkOutput("clr_total", int'(total), 0);
        checkOutput("clr_overflow", int'(overflow), 0);
        checkOutput("clr_cnt_q", int'(cntQ), val);
        holdValue(val, 5, 1'b1);
        checkOutput("clr_no_reaccept", int'(total), 0);

        // Reset mid-stream while a new value is settling
        holdValue(1, 2, 1'b0);
        applyStimulus(1, 1'b1, 1'b0, 1'b1);
        checkOutput("rst_cnt_q", int'(cntQ), 0);
        checkOutput("rst_total", int'(total), 0);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);

        // Randomized run: holds of 1..6 cycles include unsettled glitches
        for (int n = 0; n < 600; n++) begin
            val  = int'($urandom_range(CMOD - 1, 0));
            hold = int'($urandom_range(6, 1));
            for (int c = 0; c < hold; c++) begin
                applyStimulus(val,
                              ($urandom % 150) == 0,
                              ($urandom % 4) != 0,
                              ($urandom % 400) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
